// File: rtl/rom_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_mem_ctrl_pkg
//  Description : Shared types and constants for the ROM0 physical-memory
//                controller (state encoding, default strobe timing, widths).
//  Revision    : 1.0  initial release
// ============================================================================
package rom_mem_ctrl_pkg;

  // Word-address width, matches mem_addr[22:0] from the mapper
  localparam int AW = 23;
  // External memory data width
  localparam int DW = 16;

  // Default strobe timing in clk cycles
  localparam int T_RD_DEF  = 7;
  localparam int T_WR_DEF  = 6;
  localparam int T_REC_DEF = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CPU_RD = 3'd1,
    PI_RD  = 3'd2,
    PI_WR  = 3'd3,
    REC    = 3'd4
  } state_e;

  // The timer is loaded with T-1, so clog2 of the largest T is enough bits
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(T_RD_DEF, T_WR_DEF, T_REC_DEF);

endpackage
`default_nettype wire

// File: rtl/rom_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_mem_ctrl_if
//  Description : Bundle of the mapper ROM0 port, the PI loader port and the
//                external asynchronous SRAM/PSRAM pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface rom_mem_ctrl_if;
  import rom_mem_ctrl_pkg::*;

  // Mapper (console) side
  logic [AW-1:0] cpu_addr;
  logic          cpu_oe;
  logic [DW-1:0] cpu_do;
  logic          cpu_rdy;

  // PI / USB loader side
  logic          pi_req;
  logic          pi_we;
  logic [AW-1:0] pi_addr;
  logic [DW-1:0] pi_di;
  logic [DW-1:0] pi_do;
  logic          pi_ack;

  // External memory pins
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dq_o;
  logic [DW-1:0] ram_dq_i;
  logic          ram_dq_oe;
  logic          ram_ce_n;
  logic          ram_oe_n;
  logic          ram_we_n;

  // Controller view
  modport slave (
    input  cpu_addr, cpu_oe, pi_req, pi_we, pi_addr, pi_di, ram_dq_i,
    output cpu_do, cpu_rdy, pi_do, pi_ack,
           ram_addr, ram_dq_o, ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n
  );

  // Requester / memory-model view
  modport master (
    output cpu_addr, cpu_oe, pi_req, pi_we, pi_addr, pi_di, ram_dq_i,
    input  cpu_do, cpu_rdy, pi_do, pi_ack,
           ram_addr, ram_dq_o, ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n
  );

endinterface
`default_nettype wire

// File: rtl/rom_acc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_acc_timer
//  Description : Loadable down-counter with a terminal flag; times every
//                strobe phase of the memory controller.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_acc_timer #(
  parameter int W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load_i,
  input  wire logic [W-1:0] load_val_i,
  output logic              done_o
);

  logic [W-1:0] cnt_q;

  // Load on state entry, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/rom_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rom_mem_ctrl
//  Description : Single-word cached ROM0 read path plus PI loader arbitration
//                onto one asynchronous 16-bit SRAM/PSRAM with programmable
//                read, write and recovery strobe timing.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_mem_ctrl
  import rom_mem_ctrl_pkg::*;
#(
  parameter int T_RD  = T_RD_DEF,
  parameter int T_WR  = T_WR_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  rom_mem_ctrl_if.slave bus
);

  localparam int CW = cnt_width(T_RD, T_WR, T_REC);

  state_e        state_q, state_d;

  logic [AW-1:0] cpu_addr_q;
  logic          cpu_oe_q;
  logic          pi_req_q;

  logic [AW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;

  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_dq_o_q, ram_dq_o_d;
  logic          ram_dq_oe_q, ram_dq_oe_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;

  logic [DW-1:0] cpu_do_q, cpu_do_d;
  logic [DW-1:0] pi_do_q, pi_do_d;
  logic          pi_ack_q, pi_ack_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;
  logic          hit;

  // The single cached word serves the console whenever its tag matches
  assign hit = valid_q && (tag_q == cpu_addr_q);

  rom_acc_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Register the requests once; all arbitration works on these copies so a
  // console read and a PI request raised together are seen together
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_addr_q <= '0;
      cpu_oe_q   <= 1'b0;
      pi_req_q   <= 1'b0;
    end else begin
      cpu_addr_q <= bus.cpu_addr;
      cpu_oe_q   <= bus.cpu_oe;
      pi_req_q   <= bus.pi_req;
    end
  end

  // Next-state, strobe and result logic; strobes are launched registered
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    ram_addr_d  = ram_addr_q;
    ram_dq_o_d  = ram_dq_o_q;
    ram_dq_oe_d = ram_dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    cpu_do_d    = cpu_do_q;
    pi_do_d     = pi_do_q;
    pi_ack_d    = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      IDLE: begin
        if (cpu_oe_q && !hit) begin
          state_d    = CPU_RD;
          ram_addr_d = cpu_addr_q;
          ce_n_d     = 1'b0;
          oe_n_d     = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = CW'(T_RD - 1);
        end else if (pi_req_q) begin
          ram_addr_d = bus.pi_addr;
          ce_n_d     = 1'b0;
          tmr_load   = 1'b1;
          if (bus.pi_we) begin
            state_d     = PI_WR;
            ram_dq_o_d  = bus.pi_di;
            ram_dq_oe_d = 1'b1;
            we_n_d      = 1'b0;
            tmr_val     = CW'(T_WR - 1);
            // The cached word becomes stale as soon as its address is written
            if (tag_q == bus.pi_addr) begin
              valid_d = 1'b0;
            end
          end else begin
            state_d = PI_RD;
            oe_n_d  = 1'b0;
            tmr_val = CW'(T_RD - 1);
          end
        end
      end

      CPU_RD: begin
        if (tmr_done) begin
          state_d  = REC;
          cpu_do_d = bus.ram_dq_i;
          tag_d    = ram_addr_q;
          valid_d  = 1'b1;
          ce_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CW'(T_REC - 1);
        end
      end

      PI_RD: begin
        if (tmr_done) begin
          state_d  = REC;
          pi_do_d  = bus.ram_dq_i;
          pi_ack_d = 1'b1;
          ce_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CW'(T_REC - 1);
        end
      end

      PI_WR: begin
        if (tmr_done) begin
          state_d     = REC;
          pi_ack_d    = 1'b1;
          ce_n_d      = 1'b1;
          we_n_d      = 1'b1;
          ram_dq_oe_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = CW'(T_REC - 1);
        end
      end

      REC: begin
        // Address and write data simply hold; they only change on a new access
        if (tmr_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_dq_o_q  <= '0;
      ram_dq_oe_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_do_q    <= '0;
      pi_do_q     <= '0;
      pi_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      ram_addr_q  <= ram_addr_d;
      ram_dq_o_q  <= ram_dq_o_d;
      ram_dq_oe_q <= ram_dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      cpu_do_q    <= cpu_do_d;
      pi_do_q     <= pi_do_d;
      pi_ack_q    <= pi_ack_d;
    end
  end

  assign bus.cpu_do    = cpu_do_q;
  assign bus.cpu_rdy   = cpu_oe_q && hit;
  assign bus.pi_do     = pi_do_q;
  assign bus.pi_ack    = pi_ack_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dq_o  = ram_dq_o_q;
  assign bus.ram_dq_oe = ram_dq_oe_q;
  assign bus.ram_ce_n  = ce_n_q;
  assign bus.ram_oe_n  = oe_n_q;
  assign bus.ram_we_n  = we_n_q;

endmodule
`default_nettype wire
